// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode map, FSM state encoding and op classification shared
// by the sequential ALU top and its iterative multiply/divide datapath.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that go through the bit-serial datapath (div-by-zero is filtered by the caller)
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: bit-serial unsigned multiply (shift-add) and restoring
// divide. One WIDTH-bit adder is shared by both; hi/lo registers hold
// partial-product/multiplier for mul and remainder/quotient for div.
// The *_nxt outputs are the values after the current step, so the caller
// can capture the final result on the same edge as the last step.
module seq_muldiv_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             last,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_s;
  logic             ge;

  // Shared adder: mul accumulates the multiplicand, div trial-subtracts the divisor.
  // For div the shifted remainder is WIDTH+1 bits; when its top bit is set it
  // always exceeds the divisor, so only the low WIDTH bits go through the adder.
  always_comb begin
    if (div_q) begin
      add_x   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      add_y   = ~opnd_q;
      add_cin = 1'b1;
    end else begin
      add_x   = hi_q;
      add_y   = lo_q[0] ? opnd_q : '0;
      add_cin = 1'b0;
    end
    add_s = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    ge    = hi_q[WIDTH-1] | add_s[WIDTH];
    if (div_q) begin
      hi_nxt = ge ? add_s[WIDTH-1:0] : add_x;
      lo_nxt = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_nxt = add_s[WIDTH:1];
      lo_nxt = {add_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state for operand registers and the down-counting bit counter
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = is_div ? a_in : b_in;
      opnd_d = is_div ? b_in : a_in;
      div_d  = is_div;
      cnt_d  = CW'(WIDTH);
    end else if (step) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign last = step && (cnt_q == CW'(1));

  // Datapath registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_param_alu.sv
// seq_param_alu: registered WIDTH-bit ALU with start/ready/done handshake.
// Optional build macro SEQ_ALU_DIV_REM_EN: div also returns the remainder in
// the upper half of result (operand a for div-by-zero); otherwise that half is 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready=1, waiting for start; result/flags hold last value
// RUN     | bit-serial mul/div, WIDTH steps
// DONE    | done=1 for one cycle, result/flags freshly updated
module seq_param_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               ovf,
  output logic               div_zero
);

  localparam int RW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [RW-1:0]    result_q, result_d;
  logic             ready_q, ready_d, done_q, done_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

  logic             mu_load, mu_step, mu_last;
  logic [WIDTH-1:0] mu_hi_nxt, mu_lo_nxt;
  logic [WIDTH-1:0] div_rem, div0_rem;
  logic [RW-1:0]    mc_result;

  logic [WIDTH:0]   add_sum;
  logic [RW-1:0]    sub_diff;
  logic [RW-1:0]    sc_result;
  logic             sc_carry, sc_ovf, sc_dz;

`ifdef SEQ_ALU_DIV_REM_EN
  assign div_rem  = mu_hi_nxt;
  assign div0_rem = a;
`else
  assign div_rem  = '0;
  assign div0_rem = '0;
`endif

  assign mu_step   = (state_q == ST_RUN);
  assign mc_result = (op_q == OP_MUL) ? {mu_hi_nxt, mu_lo_nxt} : {div_rem, mu_lo_nxt};

  seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk_sys (CLOCK_50),
    .rst     (rst),
    .load    (mu_load),
    .is_div  (op == OP_DIV),
    .step    (mu_step),
    .a_in    (a),
    .b_in    (b),
    .last    (mu_last),
    .hi_nxt  (mu_hi_nxt),
    .lo_nxt  (mu_lo_nxt)
  );

  // Single-cycle ops evaluated straight from the live inputs at accept
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_diff  = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_dz     = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = {{(WIDTH-1){1'b0}}, add_sum};
        sc_carry  = add_sum[WIDTH];
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_diff;
        sc_carry  = (a < b);
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        sc_result = {div0_rem, {WIDTH{1'b1}}};
        sc_dz     = 1'b1;
      end
      OP_SHL:  sc_result = {{WIDTH{1'b0}}, a[WIDTH-2:0], 1'b0};
      OP_SHR:  sc_result = {{WIDTH{1'b0}}, 1'b0, a[WIDTH-1:1]};
      OP_ROL:  sc_result = {{WIDTH{1'b0}}, a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  sc_result = {{WIDTH{1'b0}}, a[0], a[WIDTH-1:1]};
      OP_AND:  sc_result = {{WIDTH{1'b0}}, a & b};
      OP_OR:   sc_result = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  sc_result = {{WIDTH{1'b0}}, a ^ b};
      OP_NOR:  sc_result = {{WIDTH{1'b0}}, ~(a | b)};
      OP_NAND: sc_result = {{WIDTH{1'b0}}, ~(a & b)};
      OP_XNOR: sc_result = {{WIDTH{1'b0}}, ~(a ^ b)};
      OP_GT:   sc_result = {{(RW-1){1'b0}}, (a > b)};
      OP_EQ:   sc_result = {{(RW-1){1'b0}}, (a == b)};
      default: sc_result = '0;
    endcase
  end

  // FSM next-state; result/flags are only written on the edge entering DONE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    mu_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op;
          if (is_multicycle(op) && ((op != OP_DIV) || (b != '0))) begin
            mu_load = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d  = ST_DONE;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            carry_d  = sc_carry;
            ovf_d    = sc_ovf;
            dz_d     = sc_dz;
          end
        end
      end
      ST_RUN: begin
        if (mu_last) begin
          state_d  = ST_DONE;
          result_d = mc_result;
          zero_d   = (mc_result == '0);
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, captured op, result and flag registers; reset aborts any op in flight
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign ovf      = ovf_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_param_alu.sv
// tb_seq_param_alu: scoreboard bench for seq_param_alu at WIDTH=4.
// Expected results come from an integer-arithmetic model, are queued at
// accept and compared (with latency) when done pulses.
module tb_seq_param_alu;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          CLOCK_50 = 1'b0;
  logic          rst, start;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          ready, done, zero, carry, ovf, div_zero;
  logic [RW-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          dz;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];

  seq_param_alu #(.WIDTH(W)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .ovf      (ovf),
    .div_zero (div_zero)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int ix, iy, s, r, mask, smax, smin;
    e    = '0;
    mask = (1 << W) - 1;
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    ix   = int'(x);
    iy   = int'(y);
    r    = 0;
    e.lat = 1;
    case (o)
      4'h0: begin
        r = ix + iy;
        e.carry = (r > mask);
        s = to_signed(ix) + to_signed(iy);
        e.ovf = (s > smax) || (s < smin);
      end
      4'h1: begin
        r = ix - iy;
        e.carry = (ix < iy);
        s = to_signed(ix) - to_signed(iy);
        e.ovf = (s > smax) || (s < smin);
      end
      4'h2: begin
        r = ix * iy;
        e.lat = W + 1;
      end
      4'h3: begin
        if (iy == 0) begin
          r = mask;
          e.dz = 1'b1;
`ifdef SEQ_ALU_DIV_REM_EN
          r = r | (ix << W);
`endif
        end else begin
          r = ix / iy;
`ifdef SEQ_ALU_DIV_REM_EN
          r = r | ((ix % iy) << W);
`endif
          e.lat = W + 1;
        end
      end
      4'h4: r = (ix << 1) & mask;
      4'h5: r = ix >> 1;
      4'h6: r = ((ix << 1) | (ix >> (W - 1))) & mask;
      4'h7: r = ((ix >> 1) | ((ix & 1) << (W - 1))) & mask;
      4'h8: r = ix & iy;
      4'h9: r = ix | iy;
      4'hA: r = ix ^ iy;
      4'hB: r = ~(ix | iy) & mask;
      4'hC: r = ~(ix & iy) & mask;
      4'hD: r = ~(ix ^ iy) & mask;
      4'hE: r = (ix > iy) ? 1 : 0;
      default: r = (ix == iy) ? 1 : 0;
    endcase
    e.res  = RW'(r);
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Pop and compare the oldest expectation on each done pulse
  always @(negedge CLOCK_50) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      check_eq("done_has_pending_op", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("result", result, e.res);
        check_eq("zero", zero, e.zero);
        check_eq("carry", carry, e.carry);
        check_eq("ovf", ovf, e.ovf);
        check_eq("div_zero", div_zero, e.dz);
        check_eq("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_eq("ready_before_start", ready, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    wait_ready();
    op = o; a = x; b = y; start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    e = model(o, x, y);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge CLOCK_50);
    start = 1'b0;
    op = 4'($urandom);
    a  = W'($urandom);
    b  = W'($urandom);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [3:0] ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_carry", carry, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_div_zero", div_zero, 0);
    rst = 1'b0;

    run_op(4'h1, 4'd3, 4'd7);
    check_eq("tp_sub_res", result, 8'hFC);
    check_eq("tp_sub_carry", carry, 1);
    run_op(4'h2, 4'd15, 4'd15);
    check_eq("tp_mul_res", result, 8'hE1);
    run_op(4'h3, 4'd13, 4'd4);
`ifdef SEQ_ALU_DIV_REM_EN
    check_eq("tp_div_res", result, 8'h13);
`else
    check_eq("tp_div_res", result, 8'h03);
`endif
    run_op(4'h3, 4'd9, 4'd0);
`ifdef SEQ_ALU_DIV_REM_EN
    check_eq("tp_div0_res", result, 8'h9F);
`else
    check_eq("tp_div0_res", result, 8'h0F);
`endif
    check_eq("tp_div0_flag", div_zero, 1);
    run_op(4'h6, 4'b1001, 4'd0);
    check_eq("tp_rol_res", result, 8'h03);
    run_op(4'h7, 4'b1001, 4'd0);
    check_eq("tp_ror_res", result, 8'h0C);
    run_op(4'hC, 4'hF, 4'hF);
    check_eq("tp_nand_zero", zero, 1);

    // mul with a second start during RUN that must be ignored
    wait_ready();
    op = 4'h2; a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    begin
      exp_t e;
      e = model(4'h2, 4'd15, 4'd15);
      e.acc = cyc;
      sb.push_back(e);
    end
    d0 = done_cnt;
    for (int k = 1; k <= W; k++) begin
      @(negedge CLOCK_50);
      check_eq("mul_busy_ready", ready, 0);
      if (k == 2) begin
        start = 1'b1; op = 4'h0; a = 4'd1; b = 4'd1;
      end else begin
        start = 1'b0;
      end
    end
    wait_drain();
    repeat (4) @(negedge CLOCK_50);
    check_eq("mul_single_done", done_cnt - d0, 1);
    check_eq("mul_ignored_res", result, 8'hE1);

    // reset in the middle of a divide
    wait_ready();
    op = 4'h3; a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    d0 = done_cnt;
    @(negedge CLOCK_50);
    start = 1'b0;
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    check_eq("midrst_ready", ready, 1);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_done", done, 0);
    repeat (W + 3) @(negedge CLOCK_50);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    run_op(4'h0, 4'd8, 4'd8);
    check_eq("postrst_add_res", result, 8'h10);
    check_eq("postrst_add_ovf", ovf, 1);

    // boundaries
    run_op(4'h0, 4'd15, 4'd15);
    run_op(4'h0, 4'd7, 4'd1);
    run_op(4'h1, 4'd0, 4'd15);
    run_op(4'h1, 4'd8, 4'd1);
    run_op(4'h1, 4'd5, 4'd5);
    run_op(4'h2, 4'd0, 4'd9);
    run_op(4'h3, 4'd15, 4'd1);
    run_op(4'h3, 4'd3, 4'd15);
    run_op(4'h4, 4'd8, 4'd0);
    run_op(4'h5, 4'd1, 4'd0);
    run_op(4'hE, 4'd5, 4'd5);
    run_op(4'hE, 4'd6, 4'd5);
    run_op(4'hF, 4'd7, 4'd7);
    run_op(4'hB, 4'd0, 4'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op(ro, ra, rb);
    end

    repeat (3) @(negedge CLOCK_50);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
